nibble_serial_adder: RTL and testbench

//  Multi-cycle WIDTH-bit adder that adds one 4-bit nibble per clock, LSB nibble first.

---
 rtl/nibble_serial_adder.sv | 166 ++++++++++++++++
 tb/tb_nibble_serial_adder.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder
//   Multi-cycle WIDTH-bit adder that consumes one 4-bit nibble per clock, LSB nibble first,
//   with the ripple carry registered between nibbles. The group propagate/generate terms
//   and the signed overflow are produced alongside the sum.
//
// Ports
//   Clk    in   clock, rising edge
//   Reset  in   asynchronous, active-high reset
//   start  in   request; sampled only in IDLE or DONE
//   A, B   in   operands, captured on the accepted start edge
//   Cin    in   carry-in, captured on the accepted start edge
//   busy   out  high while nibbles are being added
//   done   out  one-cycle pulse; S/Cout/V/P/G valid from this cycle on
//   S      out  registered sum (wraps mod 2^WIDTH)
//   Cout   out  carry out of the MSB
//   V      out  two's-complement overflow
//   P      out  group propagate: AND over all bits of (A^B)
//   G      out  group generate: carry out that would result with Cin=0
module nibble_serial_adder #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             V,
    output logic             P,
    output logic             G
);

    localparam int unsigned N    = WIDTH / 4;
    localparam int unsigned IdxW = $clog2(N);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic              carry_q, carry_d;
    logic              gen_q, gen_d;
    logic              prop_q, prop_d;
    logic [WIDTH-1:0]  s_q, s_d;
    logic              cout_q, cout_d;
    logic              v_q, v_d;
    logic              p_q, p_d;
    logic              g_q, g_d;

    // Operands are shifted right each RUN cycle, so the current nibble is always bits [3:0].
    logic [3:0] a_nib, b_nib, nib_t, nib_g;
    logic [4:0] nib_sum;
    logic       nib_p, nib_gen, last_nib;

    always_comb begin
        a_nib    = a_q[3:0];
        b_nib    = b_q[3:0];
        nib_sum  = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry_q};
        nib_t    = a_nib ^ b_nib;
        nib_g    = a_nib & b_nib;
        nib_p    = &nib_t;
        // Carry out of this nibble with a zero carry-in (lookahead form).
        nib_gen  = nib_g[3] | (nib_t[3] & nib_g[2]) | (nib_t[3] & nib_t[2] & nib_g[1]) |
                   (nib_t[3] & nib_t[2] & nib_t[1] & nib_g[0]);
        last_nib = (idx_q == IdxW'(N - 1));
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        gen_d   = gen_q;
        prop_d  = prop_q;
        s_d     = s_q;
        cout_d  = cout_q;
        v_d     = v_q;
        p_d     = p_q;
        g_d     = g_q;

        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StRun;
                    a_d     = A;
                    b_d     = B;
                    carry_d = Cin;
                    gen_d   = 1'b0;
                    prop_d  = 1'b1;
                    idx_d   = '0;
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                a_d                         = a_q >> 4;
                b_d                         = b_q >> 4;
                acc_d[{idx_q, 2'b00} +: 4]  = nib_sum[3:0];
                carry_d                     = nib_sum[4];
                gen_d                       = nib_gen | (nib_p & gen_q);
                prop_d                      = prop_q & nib_p;
                idx_d                       = idx_q + IdxW'(1);
                if (last_nib) begin
                    state_d = StDone;
                    idx_d   = '0;
                    s_d     = acc_d;
                    cout_d  = nib_sum[4];
                    // The last nibble carries the operand and sum sign bits.
                    v_d     = (a_nib[3] == b_nib[3]) && (nib_sum[3] != a_nib[3]);
                    p_d     = prop_d;
                    g_d     = gen_d;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= StIdle;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            gen_q   <= 1'b0;
            prop_q  <= 1'b0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            v_q     <= 1'b0;
            p_q     <= 1'b0;
            g_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            gen_q   <= gen_d;
            prop_q  <= prop_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            v_q     <= v_d;
            p_q     <= p_d;
            g_q     <= g_d;
        end
    end

    assign busy = (state_q == StRun);
    assign done = (state_q == StDone);
    assign S    = s_q;
    assign Cout = cout_q;
    assign V    = v_q;
    assign P    = p_q;
    assign G    = g_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
module tb_nibble_serial_adder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start = 1'b0;
    logic [15:0] a = '0, b = '0;
    logic        cin = 1'b0;
    logic        busy, done, cout, v, p, g;
    logic [15:0] s;

    logic        start8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        cin8 = 1'b0;
    logic        busy8, done8, cout8, v8, p8, g8;
    logic [7:0]  s8;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    nibble_serial_adder #(.WIDTH(16)) u_dut (
        .Clk(clk), .Reset(rst), .start(start), .A(a), .B(b), .Cin(cin),
        .busy(busy), .done(done), .S(s), .Cout(cout), .V(v), .P(p), .G(g)
    );

    nibble_serial_adder #(.WIDTH(8)) u_dut8 (
        .Clk(clk), .Reset(rst), .start(start8), .A(a8), .B(b8), .Cin(cin8),
        .busy(busy8), .done(done8), .S(s8), .Cout(cout8), .V(v8), .P(p8), .G(g8)
    );

    // Reference: whole-word arithmetic, result packed as {S, Cout, V, P, G}.
    function automatic logic [19:0] model16(input logic [15:0] x, input logic [15:0] y,
                                            input logic ci);
        logic [16:0] full, nocarry;
        logic [15:0] sum;
        full    = {1'b0, x} + {1'b0, y} + {16'd0, ci};
        nocarry = {1'b0, x} + {1'b0, y};
        sum     = full[15:0];
        return {sum, full[16], (x[15] == y[15]) && (sum[15] != x[15]), &(x ^ y), nocarry[16]};
    endfunction

    function automatic logic [11:0] model8(input logic [7:0] x, input logic [7:0] y,
                                           input logic ci);
        logic [8:0] full, nocarry;
        logic [7:0] sum;
        full    = {1'b0, x} + {1'b0, y} + {8'd0, ci};
        nocarry = {1'b0, x} + {1'b0, y};
        sum     = full[7:0];
        return {sum, full[8], (x[7] == y[7]) && (sum[7] != x[7]), &(x ^ y), nocarry[8]};
    endfunction

    // Issues one operation from a negedge; returns at the negedge where done is seen.
    task automatic do_op(input logic [15:0] av, input logic [15:0] bv, input logic cv,
                         output int busy_cnt, output bit timed_out);
        int n;
        start = 1'b1; a = av; b = bv; cin = cv;
        @(negedge clk);
        start = 1'b0;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
        busy_cnt = 0;
        n = 0;
        while (done !== 1'b1 && n < 50) begin
            if (busy === 1'b1) busy_cnt++;
            @(negedge clk);
            n++;
        end
        timed_out = (n >= 50);
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++;
        if ({busy, done, s, cout, v, p, g} !== 21'd0) begin
            bad++;
            $display("FAIL reset16: got %h want 0", {busy, done, s, cout, v, p, g});
        end
        total++;
        if ({busy8, done8, s8, cout8, v8, p8, g8} !== 13'd0) begin
            bad++;
            $display("FAIL reset8: got %h want 0", {busy8, done8, s8, cout8, v8, p8, g8});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [15:0] va [4] = '{16'hFFFF, 16'h7FFF, 16'h1234, 16'hAAAA};
        logic [15:0] vb [4] = '{16'h0001, 16'h0001, 16'h4321, 16'h5555};
        logic        vc [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [19:0] ve [4] = '{{16'h0000, 4'b1001}, {16'h8000, 4'b0100},
                                {16'h5556, 4'b0000}, {16'h0000, 4'b1010}};
        int  bc;
        bit  to;
        for (int i = 0; i < 4; i++) begin
            do_op(va[i], vb[i], vc[i], bc, to);
            total++;
            if (to || bc != 4) begin
                bad++;
                $display("FAIL dir%0d_latency: busy cycles %0d timeout %0d want 4", i, bc, to);
            end
            total++;
            if ({s, cout, v, p, g} !== ve[i]) begin
                bad++;
                $display("FAIL dir%0d_result: got %h want %h", i, {s, cout, v, p, g}, ve[i]);
            end
            @(negedge clk);
            total++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL dir%0d_pulse: done %b busy %b want 0 0", i, done, busy);
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] x, y;
        logic        c;
        logic [19:0] exp;
        int          bc;
        bit          to;
        for (int i = 0; i < 40; i++) begin
            x = 16'($urandom); y = 16'($urandom); c = 1'($urandom);
            if (i % 8 == 0) y = ~x;
            exp = model16(x, y, c);
            do_op(x, y, c, bc, to);
            total++;
            if (to || {s, cout, v, p, g} !== exp) begin
                bad++;
                $display("FAIL rand%0d %h+%h+%b: got %h want %h timeout %0d",
                         i, x, y, c, {s, cout, v, p, g}, exp, to);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_ignore_start();
        logic [19:0] prev, exp, res;
        int dones, bc;
        bit to;
        do_op(16'h0F0F, 16'h0101, 1'b0, bc, to);
        prev = model16(16'h0F0F, 16'h0101, 1'b0);
        @(negedge clk);
        exp = model16(16'h1234, 16'h0FFF, 1'b0);
        res = '0;
        dones = 0;
        start = 1'b1; a = 16'h1234; b = 16'h0FFF; cin = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 12; k++) begin
            if (k == 1) begin
                start = 1'b1; a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1;
                total++;
                if ({s, cout, v, p, g} !== prev) begin
                    bad++;
                    $display("FAIL hold_during_run: got %h want %h", {s, cout, v, p, g}, prev);
                end
            end else begin
                start = 1'b0;
            end
            if (done === 1'b1) begin
                dones++;
                res = {s, cout, v, p, g};
            end
            @(negedge clk);
        end
        total++;
        if (dones != 1) begin
            bad++;
            $display("FAIL ignore_done_count: got %0d want 1", dones);
        end
        total++;
        if (res !== exp) begin
            bad++;
            $display("FAIL ignore_result: got %h want %h", res, exp);
        end
    endtask

    task automatic test_back_to_back();
        logic [19:0] ex, ey, rx, ry;
        int nd, t1, t2;
        ex = model16(16'h8000, 16'h8000, 1'b1);
        ey = model16(16'h00FF, 16'h0F01, 1'b0);
        rx = '0; ry = '0; nd = 0; t1 = 0; t2 = 0;
        start = 1'b1; a = 16'h8000; b = 16'h8000; cin = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 30; k++) begin
            if (done === 1'b1) begin
                nd++;
                if (nd == 1) begin
                    t1 = k; rx = {s, cout, v, p, g};
                    a = 16'h00FF; b = 16'h0F01; cin = 1'b0;
                end else begin
                    t2 = k; ry = {s, cout, v, p, g};
                end
            end else if (nd >= 1) begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        total++;
        if (nd != 2 || (t2 - t1) != 5) begin
            bad++;
            $display("FAIL b2b_spacing: dones %0d spacing %0d want 2 and 5", nd, t2 - t1);
        end
        total++;
        if (rx !== ex || ry !== ey) begin
            bad++;
            $display("FAIL b2b_results: got %h %h want %h %h", rx, ry, ex, ey);
        end
    endtask

    task automatic test_reset_mid_run();
        int bc, nd, nb;
        bit to;
        do_op(16'h1111, 16'h2222, 1'b0, bc, to);
        @(negedge clk);
        start = 1'b1; a = 16'h4444; b = 16'h4444; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        total++;
        if (s !== 16'h3333 || busy !== 1'b1) begin
            bad++;
            $display("FAIL pre_abort: S %h busy %b want 3333 1", s, busy);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if ({busy, done, s, cout, v, p, g} !== 21'd0) begin
            bad++;
            $display("FAIL abort_outputs: got %h want 0", {busy, done, s, cout, v, p, g});
        end
        @(negedge clk);
        rst = 1'b0;
        nd = 0; nb = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done === 1'b1) nd++;
            if (busy === 1'b1) nb++;
        end
        total++;
        if (nd != 0 || nb != 0) begin
            bad++;
            $display("FAIL abort_idle: dones %0d busy %0d want 0 0", nd, nb);
        end
        do_op(16'h0001, 16'h0002, 1'b0, bc, to);
        total++;
        if (to || s !== 16'h0003 || bc != 4) begin
            bad++;
            $display("FAIL after_abort: S %h busy %0d want 0003 4", s, bc);
        end
        @(negedge clk);
    endtask

    task automatic test_width8();
        logic [7:0]  x, y;
        logic        c;
        logic [11:0] exp;
        int bc, n;
        for (int i = 0; i < 6; i++) begin
            if (i == 0) begin
                x = 8'h0F; y = 8'h01; c = 1'b0;
            end else begin
                x = 8'($urandom); y = 8'($urandom); c = 1'($urandom);
            end
            exp = model8(x, y, c);
            start8 = 1'b1; a8 = x; b8 = y; cin8 = c;
            @(negedge clk);
            start8 = 1'b0;
            bc = 0; n = 0;
            while (done8 !== 1'b1 && n < 30) begin
                if (busy8 === 1'b1) bc++;
                @(negedge clk);
                n++;
            end
            total++;
            if (n >= 30 || bc != 2 || {s8, cout8, v8, p8, g8} !== exp) begin
                bad++;
                $display("FAIL w8_%0d %h+%h+%b: got %h busy %0d want %h busy 2",
                         i, x, y, c, {s8, cout8, v8, p8, g8}, bc, exp);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_run();
        test_width8();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
